// File: rtl/vec_mem_pkg.sv
// Shared types and constants for the vector memory responder.
package vec_mem_pkg;

   localparam int defRegisterSize = 8;
   localparam int defVectorSize   = 4;
   localparam int cntWidth        = $clog2(defVectorSize + 1);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      RESP
   } stateT;

   // Request as latched at the IDLE handshake.
   typedef struct packed {
      logic                                       write;
      logic [defRegisterSize-1:0]                 addr;
      logic [defVectorSize*defRegisterSize-1:0]   wdata;
   } memReqT;

endpackage

// File: rtl/vec_mem_responder_array.sv
// Single-port element-wide RAM with synchronous read (read-before-write).
module vec_mem_array #(
   parameter int dataW = 8,
   parameter int depth = 256,
   localparam int addrW = $clog2(depth)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [addrW-1:0] addr,
   input  logic [dataW-1:0] wdata,
   output logic [dataW-1:0] rdata
);

   logic [dataW-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/vec_mem_responder.sv
// Multi-cycle vector load/store responder serialising vectors over an element RAM.
// Optional macro VMEM_BOUNDS_CHECK_EN: out-of-range vectors answer with resp_err instead of wrapping.
module vec_mem_responder
   import vec_mem_pkg::*;
#(
   parameter int registerSize = defRegisterSize,
   parameter int vectorSize   = defVectorSize,
   parameter int memDepth     = 256
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic                               req_write,
   input  logic [registerSize-1:0]            req_addr,
   input  logic [vectorSize*registerSize-1:0] req_wdata,
   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [vectorSize*registerSize-1:0] resp_rdata,
   output logic                               resp_err
);

   localparam int addrW = $clog2(memDepth);

   stateT                              state, stateNext;
   memReqT                             reqQ;
   logic [cntWidth-1:0]                cnt;
   logic [vectorSize*registerSize-1:0] rdataQ;
   logic                               accept, lastStep, inRange;
   logic                               memWe;
   logic [addrW-1:0]                   memAddr;
   logic [registerSize-1:0]            memWdata, memRdata;

   assign req_ready  = (state == IDLE) && rst;
   assign accept     = req_ready && req_valid;
   assign resp_valid = (state == RESP);
   assign resp_rdata = rdataQ;

`ifdef VMEM_BOUNDS_CHECK_EN
   logic errQ;
   assign inRange  = (({1'b0, req_addr} + (registerSize+1)'(vectorSize - 1))
                      < (registerSize+1)'(memDepth));
   assign resp_err = errQ;
`else
   assign inRange  = 1'b1;
   assign resp_err = 1'b0;
`endif

   // Element address: addr+k at registerSize+1 bits, reduced modulo memDepth.
   assign memAddr = addrW'({1'b0, reqQ.addr} + (registerSize+1)'(cnt));
   assign memWe   = (state == XFER) && reqQ.write && rst;

   // Loads run one step longer so the last synchronous read can be captured.
   assign lastStep = (state == XFER) &&
                     (cnt == (reqQ.write ? cntWidth'(vectorSize - 1) : cntWidth'(vectorSize)));

   always_comb begin
      memWdata = '0;
      for (int i = 0; i < vectorSize; i++)
         if (cnt == cntWidth'(i)) memWdata = reqQ.wdata[i*registerSize +: registerSize];
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (req_valid) stateNext = inRange ? XFER : RESP;
         XFER:    if (lastStep) stateNext = RESP;
         RESP:    if (resp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         rdataQ <= '0;
`ifdef VMEM_BOUNDS_CHECK_EN
         errQ   <= 1'b0;
`endif
      end else begin
         state <= stateNext;
         if (accept) begin
            cnt    <= '0;
            rdataQ <= '0;
`ifdef VMEM_BOUNDS_CHECK_EN
            errQ   <= !inRange;
`endif
         end else if (state == XFER) begin
            cnt <= cnt + 1'b1;
            // Read data for element k arrives while the counter shows k+1.
            for (int i = 0; i < vectorSize; i++)
               if (!reqQ.write && cnt == cntWidth'(i + 1))
                  rdataQ[i*registerSize +: registerSize] <= memRdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) reqQ <= '{write: req_write, addr: req_addr, wdata: req_wdata};
   end

   vec_mem_array #(
      .dataW (registerSize),
      .depth (memDepth)
   ) uArray (
      .clk   (clk),
      .we    (memWe),
      .addr  (memAddr),
      .wdata (memWdata),
      .rdata (memRdata)
   );

endmodule

// File: tb/tb_vec_mem_responder.sv
// Randomised self-checking bench for vec_mem_responder against a vector-level memory model.
module tb_vec_mem_responder;

   localparam int RS    = 8;
   localparam int VS    = 4;
   localparam int DEPTH = 256;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic           req_write = 1'b0;
   logic [RS-1:0]  req_addr = '0;
   logic [31:0]    req_wdata = '0;
   logic           resp_valid;
   logic           resp_ready = 1'b0;
   logic [31:0]    resp_rdata;
   logic           resp_err;

   int          nChecks = 0;
   int          nFails  = 0;
   bit [7:0]    modelMem   [DEPTH];
   bit          modelKnown [DEPTH];
   logic [31:0] expRdata = '0, expMask = '1, lastRdata;
   logic        expErr = 1'b0, lastErr;
   bit          expPending = 1'b0;
   int          expLat = 0;

   vec_mem_responder #(
      .registerSize (RS),
      .vectorSize   (VS),
      .memDepth     (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Vector-level model: what a request must return, applied at acceptance.
   task automatic model(input bit w, input logic [7:0] a, input logic [31:0] wd);
      bit oob = 1'b0;
`ifdef VMEM_BOUNDS_CHECK_EN
      oob = (int'(a) + VS - 1 >= DEPTH);
`endif
      expRdata = '0;
      expMask  = '1;
      expErr   = oob;
      if (oob) expLat = 1;
      else begin
         expLat = w ? VS + 1 : VS + 2;
         for (int i = 0; i < VS; i++) begin
            int idx = (int'(a) + i) % DEPTH;
            if (w) begin
               modelMem[idx]   = wd[i*8 +: 8];
               modelKnown[idx] = 1'b1;
            end else begin
               expRdata[i*8 +: 8] = modelMem[idx];
               expMask[i*8 +: 8]  = modelKnown[idx] ? 8'hFF : 8'h00;
            end
         end
      end
      expPending = 1'b1;
   endtask

   task automatic issue(input bit w, input logic [7:0] a, input logic [31:0] wd);
      int t = 0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
      while (req_ready !== 1'b1 && t < 60) begin
         @(posedge clk); #1; t++;
      end
      check("acceptTimeout", 32'(t < 60), 32'd1);
      model(w, a, wd);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wdata = $urandom;
   endtask

   task automatic finish(input int stall);
      int lat = 1;
      while (resp_valid !== 1'b1 && lat < 60) begin
         check("reqReadyBusy", 32'(req_ready), 32'd0);
         @(posedge clk); #1; lat++;
      end
      check("latency", lat, expLat);
      repeat (stall) begin @(posedge clk); #1; end
      lastRdata = resp_rdata;
      lastErr   = resp_err;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      expPending = 1'b0;
      check("reqReadyAfterResp", 32'(req_ready), 32'd1);
   endtask

   // Per-cycle comparison of the response outputs against the model.
   always @(negedge clk) begin
      if (rst === 1'b1 && resp_valid === 1'b1) begin
         check("respExpected", 32'(expPending), 32'd1);
         check("respRdata", resp_rdata & expMask, expRdata & expMask);
         check("respErr", 32'(resp_err), 32'(expErr));
         check("reqReadyInResp", 32'(req_ready), 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rstReqReady", 32'(req_ready), 32'd0);
      check("rstRespValid", 32'(resp_valid), 32'd0);
      check("rstRdata", resp_rdata, 32'd0);
      check("rstErr", 32'(resp_err), 32'd0);
      rst = 1'b1;
      #1;
      check("relReqReady", 32'(req_ready), 32'd1);

      // Store then load.
      issue(1'b1, 8'h10, 32'h44332211); finish(0);
      check("storeRdataZero", lastRdata, 32'd0);
      issue(1'b0, 8'h10, 32'h0); finish(0);
      check("loadLit", lastRdata, 32'h44332211);
      check("loadLitErr", 32'(lastErr), 32'd0);

      // Back-pressure with a second request held pending.
      issue(1'b0, 8'h10, 32'h0);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h60; req_wdata = 32'hA5A5A5A5;
      finish(10);
      check("bpLit", lastRdata, 32'h44332211);
      issue(1'b1, 8'h60, 32'hA5A5A5A5); finish(0);

      // Partial overlap.
      issue(1'b1, 8'h20, 32'hD1C1B1A1); finish(1);
      issue(1'b1, 8'h22, 32'h81716151); finish(0);
      issue(1'b0, 8'h20, 32'h0); finish(2);
      check("overlapLit", lastRdata, 32'h6151B1A1);

`ifdef VMEM_BOUNDS_CHECK_EN
      issue(1'b1, 8'h00, 32'h0D0C0B0A); finish(0);
      issue(1'b1, 8'hFE, 32'h04030201); finish(0);
      check("boundsErrLit", 32'(lastErr), 32'd1);
      issue(1'b0, 8'h00, 32'h0); finish(0);
      check("boundsUntouched", lastRdata, 32'h0D0C0B0A);
      issue(1'b0, 8'hFC, 32'h0); finish(0);
      check("boundsInRangeErr", 32'(lastErr), 32'd0);
`else
      issue(1'b1, 8'hFE, 32'h04030201); finish(0);
      issue(1'b0, 8'hFE, 32'h0); finish(0);
      check("wrapLit", lastRdata, 32'h04030201);
      issue(1'b0, 8'h00, 32'h0); finish(0);
      check("wrapLowLit", lastRdata & 32'h0000FFFF, 32'h00000403);
`endif

      // Reset during element 2 of a store.
      issue(1'b1, 8'h40, 32'hDDCCBBAA); finish(0);
      issue(1'b1, 8'h40, 32'h44332211);
      modelKnown[8'h42] = 1'b0;
      modelMem[8'h43]   = 8'hDD;
      expPending = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("midRstRespValid", 32'(resp_valid), 32'd0);
      check("midRstReqReady", 32'(req_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("midRstRelReady", 32'(req_ready), 32'd1);
      issue(1'b0, 8'h40, 32'h0); finish(0);
      check("midRstLit", lastRdata & 32'hFF00FFFF, 32'hDD002211);

      // Randomised traffic concentrated near the wrap point and low addresses.
      for (int n = 0; n < 150; n++) begin
         bit          w  = 1'($urandom_range(0, 1));
         logic [7:0]  a  = ($urandom_range(0, 2) == 0) ? 8'(8'hF8 + $urandom_range(0, 15))
                                                        : 8'($urandom_range(0, 40));
         logic [31:0] wd = $urandom;
         issue(w, a, wd);
         finish($urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
